mem_burst_scheduler: RTL and testbench

MEM_BURST_SCHEDULER -- requirements
Module: mem_burst_scheduler

---
 rtl/mem_burst_scheduler.sv | 157 +++++++++++++++
 tb/tb_mem_burst_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_scheduler.sv
// Round-robin burst scheduler: grants one requester at a time to a shared
// memory port, counts accepted beats and pulses done on the last beat.
//
// state | meaning
// IDLE  | no grant; arbitrate among req from ptr upward
// BURST | one port granted; beats counted until beat_cnt==len_q is accepted
module mem_burst_scheduler #(
  parameter int PORTS = 16,
  parameter int LEN_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORTS-1:0]       req,
  input  logic [PORTS*LEN_W-1:0] req_len,
  output logic [PORTS-1:0]       gnt,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [LEN_W-1:0]       beat_cnt,
  output logic [PORTS-1:0]       done
);

  localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_q, state_d;
  logic [PORTS-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_q, beat_d;

  logic [IDX_W-1:0]   ptr_inc;
  logic [IDX_W-1:0]   arb_start;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic [PORTS-1:0]   arb_vec;
  logic [LEN_W-1:0]   arb_len;
  logic               arb_found;
  logic               last_beat;
  logic               win_req;
  int                 cand;

  // Port after the current winner, wrapping at PORTS-1.
  always_comb begin
    if (win_q == IDX_W'(PORTS - 1)) ptr_inc = '0;
    else                            ptr_inc = win_q + IDX_W'(1);
  end

  // Round-robin search; during a burst the finishing port is masked and the
  // search starts just after it so a back-to-back grant goes to a neighbour.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    arb_vec   = (state_q == BURST) ? (req & ~gnt_q) : req;
    arb_start = (state_q == BURST) ? ptr_inc : ptr_q;
    for (int k = 0; k < PORTS; k++) begin
      cand = int'(arb_start) + k;
      if (cand >= PORTS) cand = cand - PORTS;
      cand_idx = cand[IDX_W-1:0];
      if (!arb_found && arb_vec[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  // Burst length of the arbitration winner, captured only at grant.
  always_comb begin
    arb_len = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (arb_idx == IDX_W'(i)) arb_len = req_len[i*LEN_W +: LEN_W];
    end
  end

  // Last-beat detection and done pulse straight from the registered grant.
  always_comb begin
    last_beat = (state_q == BURST) && mem_ready && (beat_q == len_q);
    win_req   = |(req & gnt_q);
    done      = last_beat ? gnt_q : '0;
  end

  // Next-state logic: grant, beat counting, back-to-back hand-off and abort.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d        = BURST;
          gnt_d          = '0;
          gnt_d[arb_idx] = 1'b1;
          win_d          = arb_idx;
          len_d          = arb_len;
          beat_d         = '0;
        end
      end
      BURST: begin
        if (last_beat) begin
          ptr_d = ptr_inc;
          if (arb_found) begin
            gnt_d          = '0;
            gnt_d[arb_idx] = 1'b1;
            win_d          = arb_idx;
            len_d          = arb_len;
            beat_d         = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            beat_d  = '0;
          end
        end else if (!win_req) begin
          state_d = IDLE;
          gnt_d   = '0;
          beat_d  = '0;
          ptr_d   = ptr_inc;
        end else if (mem_ready) begin
          beat_d = beat_q + LEN_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end

  assign gnt       = gnt_q;
  assign mem_valid = |gnt_q;
  assign beat_cnt  = beat_q;

endmodule

// File: tb/tb_mem_burst_scheduler.sv
// Scoreboard bench for mem_burst_scheduler: a behavioural model predicts each
// cycle's grant/beat/done, a negedge monitor compares the DUT against it.
module tb_mem_burst_scheduler;
  localparam int P  = 16;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [P-1:0]    req;
  logic [P*LW-1:0] req_len;
  logic [P-1:0]    gnt;
  logic            mem_valid;
  logic            mem_ready;
  logic [LW-1:0]   beat_cnt;
  logic [P-1:0]    done;

  mem_burst_scheduler #(.PORTS(P), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .gnt(gnt),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .beat_cnt(beat_cnt), .done(done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [P-1:0]  gnt;
    logic [LW-1:0] beat;
    logic [P-1:0]  done;
  } exp_t;

  exp_t q[$];

  // Model: owner of the memory port (-1 when free), beats accepted so far,
  // captured burst length and round-robin start point.
  int m_owner = -1;
  int m_beats = 0;
  int m_len   = 0;
  int m_ptr   = 0;
  logic [P-1:0] last_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    #1;
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [P-1:0] v, input int start);
    for (int k = 0; k < P; k++) begin
      int p;
      p = (start + k) % P;
      if (v[p]) return p;
    end
    return -1;
  endfunction

  function automatic int len_of(input int p);
    logic [LW-1:0] l;
    l = req_len[p*LW +: LW];
    return int'(l);
  endfunction

  // Predict this cycle's outputs, advance the model one clock, advance time.
  task automatic step();
    exp_t e;
    logic [P-1:0] g;
    int w;
    g      = (m_owner < 0) ? '0 : (P'(1) << m_owner);
    e.gnt  = g;
    e.beat = LW'(m_beats);
    e.done = (m_owner >= 0 && mem_ready && m_beats == m_len) ? g : '0;
    q.push_back(e);
    last_done = e.done;
    if (rst) begin
      m_owner = -1; m_beats = 0; m_len = 0; m_ptr = 0;
    end else if (m_owner < 0) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin m_owner = w; m_len = len_of(w); m_beats = 0; end
    end else if (e.done != '0) begin
      m_ptr   = (m_owner + 1) % P;
      w       = pick(req & ~g, m_ptr);
      m_owner = w;
      if (w >= 0) begin m_len = len_of(w); m_beats = 0; end
    end else if (!req[m_owner]) begin
      m_ptr   = (m_owner + 1) % P;
      m_owner = -1;
    end else if (mem_ready) begin
      m_beats++;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the DUT outputs of each modelled cycle mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (gnt !== e.gnt || done !== e.done || mem_valid !== (|e.gnt) ||
          (e.gnt != '0 && beat_cnt !== e.beat)) begin
        failures++;
        $display("FAIL sb_cycle actual gnt=%h done=%h valid=%b beat=%0d required gnt=%h done=%h valid=%b beat=%0d at %0t",
                 gnt, done, mem_valid, beat_cnt, e.gnt, e.done, |e.gnt, e.beat, $time);
      end
    end
  end

  task automatic set_len(input int p, input int l);
    req_len[p*LW +: LW] = LW'(l);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; mem_ready = 1'b0; req_len = '0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_len = '0; mem_ready = 1'b0; last_done = '0;
    @(posedge clk);
    #1;
    do_reset();
    check("reset_gnt", gnt, 0);
    check("reset_valid", mem_valid, 0);
    check("reset_beat", beat_cnt, 0);

    // Single port, length 4 beats.
    set_len(0, 3); req = 16'h0001; mem_ready = 1'b1;
    step();
    check("single_gnt", gnt, 16'h0001);
    for (int b = 0; b < 4; b++) begin
      check("single_beat", beat_cnt, b);
      check("single_done", done, (b == 3) ? 16'h0001 : 16'h0000);
      step();
    end
    req = '0;
    step();
    check("single_idle", gnt, 0);

    // Full rotation with single-beat bursts and no bubbles.
    do_reset();
    req = 16'hFFFF; mem_ready = 1'b1;
    step();
    for (int i = 0; i < 17; i++) begin
      check("rotate_gnt", gnt, 16'h0001 << (i % 16));
      step();
    end

    // Stall with mem_ready low.
    do_reset();
    set_len(2, 1); req = 16'h0004;
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall_gnt", gnt, 16'h0004);
      check("stall_beat", beat_cnt, 0);
      step();
    end
    mem_ready = 1'b1;
    check("stall_done0", done, 0);
    step();
    check("stall_done1", done, 16'h0004);
    step();
    req = '0;
    step();

    // Abort of port 5, then wrap to port 0 from ptr=6.
    do_reset();
    set_len(5, 7); req = 16'h0020; mem_ready = 1'b1;
    step(); step(); step(); step();
    check("abort_beat", beat_cnt, 3);
    req = '0;
    check("abort_nodone", done, 0);
    step();
    check("abort_gnt", gnt, 0);
    req = 16'h0021;
    step();
    check("abort_wrap", gnt, 16'h0001);

    // Reset in the middle of a port 9 burst.
    do_reset();
    set_len(9, 7); req = 16'h0200; mem_ready = 1'b1;
    step(); step(); step();
    check("rstmid_beat", beat_cnt, 2);
    rst = 1'b1;
    step();
    check("rstmid_gnt", gnt, 0);
    check("rstmid_beatclr", beat_cnt, 0);
    rst = 1'b0; req = 16'h0201;
    step();
    check("rstmid_first", gnt, 16'h0001);

    // Lone re-requester sees one idle cycle between bursts.
    do_reset();
    req = 16'h0010; mem_ready = 1'b1;
    step();
    check("lone_gnt", gnt, 16'h0010);
    check("lone_done", done, 16'h0010);
    step();
    check("lone_bubble", gnt, 0);
    step();
    check("lone_regnt", gnt, 16'h0010);

    // Maximum length: 16 beats, req_len churned under the burst.
    do_reset();
    set_len(3, 15); req = 16'h0008; mem_ready = 1'b1;
    step();
    for (int b = 0; b < 16; b++) begin
      check("maxlen_beat", beat_cnt, b);
      check("maxlen_done", done, (b == 15) ? 16'h0008 : 16'h0000);
      req_len = {$urandom, $urandom};
      step();
    end
    req = '0;
    step();

    // Randomized traffic checked only through the scoreboard.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < P; p++) begin
        if (req[p] && last_done[p])                 req[p] = 1'b0;
        else if (req[p] && $urandom_range(0, 39) == 0) req[p] = 1'b0;
        else if (!req[p] && $urandom_range(0, 3) == 0) req[p] = 1'b1;
      end
      req_len   = {$urandom, $urandom};
      mem_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    @(negedge clk);
    #1;
    check("sb_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
